// File: rtl/brainfuck_core.sv
// Multi-cycle Brainfuck interpreter: sync code ROM fetch, comb-read/sync-write data RAM, char I/O handshake.
// Optional macro BF_PROBE_EN: when defined, probe exposes the FSM state code; otherwise probe is tied to 0.
module brainfuck_core #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            code_in,
  output logic [ADDR_WIDTH-1:0] addr_code,
  input  logic [7:0]            data_in,
  output logic [ADDR_WIDTH-1:0] addr_array,
  output logic [7:0]            data_out,
  output logic                  write_rq,
  input  logic                  receivingChar,
  input  logic [7:0]            receivedChar,
  output logic                  sendingChar,
  output logic [7:0]            sendedChar,
  output logic [3:0]            probe
);

  typedef enum logic [3:0] {
    FETCH      = 4'h0,
    EXEC       = 4'h1,
    WAIT_IN    = 4'h2,
    FWD_FETCH  = 4'h3,
    FWD        = 4'h4,
    BACK_FETCH = 4'h5,
    BACK       = 4'h6,
    HALT       = 4'hF
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   D_ONE  = (ADDR_WIDTH + 1)'(1);

  localparam logic [7:0] OP_INC  = 8'h2B;
  localparam logic [7:0] OP_DEC  = 8'h2D;
  localparam logic [7:0] OP_RGT  = 8'h3E;
  localparam logic [7:0] OP_LFT  = 8'h3C;
  localparam logic [7:0] OP_OUT  = 8'h2E;
  localparam logic [7:0] OP_IN   = 8'h2C;
  localparam logic [7:0] OP_LOOP = 8'h5B;
  localparam logic [7:0] OP_END  = 8'h5D;
  localparam logic [7:0] OP_HALT = 8'h00;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] dp_q, dp_d;
  logic [ADDR_WIDTH:0]   depth_q, depth_d;
  logic                  send_q, send_d;
  logic [7:0]            char_q, char_d;
  logic                  wr_rq;
  logic [7:0]            wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      dp_q    <= '0;
      depth_q <= '0;
      send_q  <= 1'b0;
      char_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      dp_q    <= dp_d;
      depth_q <= depth_d;
      send_q  <= send_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dp_d    = dp_q;
    depth_d = depth_q;
    send_d  = 1'b0;
    char_d  = char_q;
    wr_rq   = 1'b0;
    wr_data = 8'h00;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        case (code_in)
          OP_INC: begin
            wr_rq   = 1'b1;
            wr_data = data_in + 8'd1;
            pc_d    = pc_q + PC_ONE;
          end
          OP_DEC: begin
            wr_rq   = 1'b1;
            wr_data = data_in - 8'd1;
            pc_d    = pc_q + PC_ONE;
          end
          OP_RGT: begin
            dp_d = dp_q + PC_ONE;
            pc_d = pc_q + PC_ONE;
          end
          OP_LFT: begin
            dp_d = dp_q - PC_ONE;
            pc_d = pc_q + PC_ONE;
          end
          OP_OUT: begin
            send_d = 1'b1;
            char_d = data_in;
            pc_d   = pc_q + PC_ONE;
          end
          OP_IN: state_d = WAIT_IN;
          OP_LOOP: begin
            pc_d = pc_q + PC_ONE;
            if (data_in == 8'h00) begin
              depth_d = D_ONE;
              state_d = FWD_FETCH;
            end
          end
          OP_END: begin
            if (data_in == 8'h00) begin
              pc_d = pc_q + PC_ONE;
            end else begin
              depth_d = D_ONE;
              pc_d    = pc_q - PC_ONE;
              state_d = BACK_FETCH;
            end
          end
          OP_HALT: state_d = HALT;
          default: pc_d = pc_q + PC_ONE;
        endcase
      end
      WAIT_IN: begin
        if (receivingChar) begin
          wr_rq   = 1'b1;
          wr_data = receivedChar;
          pc_d    = pc_q + PC_ONE;
          state_d = FETCH;
        end
      end
      FWD_FETCH:  state_d = FWD;
      BACK_FETCH: state_d = BACK;
      FWD: begin
        if (code_in == OP_HALT) begin
          state_d = HALT;
        end else begin
          if (code_in == OP_LOOP)     depth_d = depth_q + D_ONE;
          else if (code_in == OP_END) depth_d = depth_q - D_ONE;
          pc_d    = pc_q + PC_ONE;
          state_d = (depth_d == '0) ? FETCH : FWD_FETCH;
        end
      end
      BACK: begin
        if (code_in == OP_HALT) begin
          state_d = HALT;
        end else begin
          if (code_in == OP_END)       depth_d = depth_q + D_ONE;
          else if (code_in == OP_LOOP) depth_d = depth_q - D_ONE;
          // Matching '[' found: resume just past it, otherwise keep walking backwards.
          if (depth_d == '0) begin
            pc_d    = pc_q + PC_ONE;
            state_d = FETCH;
          end else begin
            pc_d    = pc_q - PC_ONE;
            state_d = BACK_FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Write strobe is combinational, so gate it with reset to keep RAM untouched while reset is high.
  assign write_rq    = wr_rq & ~reset;
  assign data_out    = reset ? 8'h00 : wr_data;
  assign addr_code   = pc_q;
  assign addr_array  = dp_q;
  assign sendingChar = send_q;
  assign sendedChar  = char_q;

`ifdef BF_PROBE_EN
  assign probe = state_q;
`else
  assign probe = 4'h0;
`endif

endmodule

// File: tb/tb_brainfuck_core.sv
// Bench for brainfuck_core (ADDR_WIDTH=5): ROM/RAM models, output-char scoreboard and directed programs.
module tb_brainfuck_core;
  localparam int AW = 5;

`ifdef BF_PROBE_EN
  localparam logic [3:0] P_HALT = 4'hF;
  localparam logic [3:0] P_WAIT = 4'h2;
`else
  localparam logic [3:0] P_HALT = 4'h0;
  localparam logic [3:0] P_WAIT = 4'h0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    code_in;
  logic [AW-1:0] addr_code;
  logic [7:0]    data_in;
  logic [AW-1:0] addr_array;
  logic [7:0]    data_out;
  logic          write_rq;
  logic          receivingChar = 1'b0;
  logic [7:0]    receivedChar = 8'h00;
  logic          sendingChar;
  logic [7:0]    sendedChar;
  logic [3:0]    probe;

  logic [7:0] rom [32];
  logic [7:0] ram [32];
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  brainfuck_core #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .code_in(code_in), .addr_code(addr_code),
    .data_in(data_in), .addr_array(addr_array), .data_out(data_out), .write_rq(write_rq),
    .receivingChar(receivingChar), .receivedChar(receivedChar),
    .sendingChar(sendingChar), .sendedChar(sendedChar), .probe(probe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) code_in <= rom[addr_code];
  assign data_in = ram[addr_array];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
    end else if (write_rq) begin
      ram[addr_array] <= data_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sendingChar) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_send: got 0x%0h expected none", sendedChar);
        end else begin
          check("send_char", {24'h0, sendedChar}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic load(input string prog);
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) rom[i] = prog[i];
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input string prog);
    reset = 1'b1;
    load(prog);
    run(3);
    reset = 1'b0;
  endtask

  initial begin
    load("");
    run(5);
    #1;
    check("rst_addr_code", {27'h0, addr_code}, 32'd0);
    check("rst_addr_array", {27'h0, addr_array}, 32'd0);
    check("rst_write_rq", {31'h0, write_rq}, 32'd0);
    check("rst_sending", {31'h0, sendingChar}, 32'd0);
    check("rst_sended", {24'h0, sendedChar}, 32'd0);
    check("rst_probe", {28'h0, probe}, 32'd0);

    start("+++.");
    exp_q.push_back(8'h03);
    run(30);
    check("t2_pc", {27'h0, addr_code}, 32'd4);
    check("t2_probe", {28'h0, probe}, {28'h0, P_HALT});
    run(5);
    check("t2_pc_frozen", {27'h0, addr_code}, 32'd4);
    check("t2_pending", exp_q.size(), 32'd0);

    start("<-");
    run(20);
    check("t3_dp", {27'h0, addr_array}, 32'd31);
    check("t3_ram31", {24'h0, ram[31]}, 32'hFF);
    check("t3_pc", {27'h0, addr_code}, 32'd2);

    start("++[->+<]>.");
    exp_q.push_back(8'h02);
    run(150);
    check("t4_ram0", {24'h0, ram[0]}, 32'h00);
    check("t4_ram1", {24'h0, ram[1]}, 32'h02);
    check("t4_pc", {27'h0, addr_code}, 32'd10);
    check("t4_pending", exp_q.size(), 32'd0);

    start(",.");
    exp_q.push_back(8'h41);
    run(6);
    check("t5_probe_wait", {28'h0, probe}, {28'h0, P_WAIT});
    check("t5_no_write", {31'h0, write_rq}, 32'd0);
    receivingChar = 1'b1;
    receivedChar  = 8'h41;
    #1;
    check("t5_write_rq", {31'h0, write_rq}, 32'd1);
    check("t5_data_out", {24'h0, data_out}, 32'h41);
    @(negedge clk);
    receivingChar = 1'b0;
    receivedChar  = 8'h00;
    run(20);
    check("t5_ram0", {24'h0, ram[0]}, 32'h41);
    check("t5_pc", {27'h0, addr_code}, 32'd2);
    check("t5_pending", exp_q.size(), 32'd0);

    start("[+++]+.");
    run(3);
    reset = 1'b1;
    #1;
    check("t6_rst_pc", {27'h0, addr_code}, 32'd0);
    check("t6_rst_dp", {27'h0, addr_array}, 32'd0);
    check("t6_rst_wr", {31'h0, write_rq}, 32'd0);
    run(2);
    reset = 1'b0;
    exp_q.push_back(8'h01);
    run(40);
    check("t6_ram0", {24'h0, ram[0]}, 32'h01);
    check("t6_pc", {27'h0, addr_code}, 32'd7);
    check("t6_probe", {28'h0, probe}, {28'h0, P_HALT});
    check("t6_pending", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
